// File: rtl/beam_threshold_loader_if.sv
// Bus between the register-side threshold writer and the beam threshold loader.
// The slave side belongs to the loader, the master side to whoever drives it.
interface beam_threshold_loader_if #(
    parameter int ADDRW = 6
);
    logic             thr_we_i;
    logic             thr_set_i;
    logic [ADDRW-1:0] thr_addr_i;
    logic [17:0]      thr_dat_i;
    logic             load_req_i;
    logic [1:0]       load_mask_i;
    logic [35:0]      thresh_o;
    logic [1:0]       thresh_wr_o;
    logic [1:0]       thresh_update_o;
    logic             busy_o;
    logic             done_o;
    logic             wr_err_o;
    logic [1:0]       fsm_state_o;

    modport slave (
        input  thr_we_i, thr_set_i, thr_addr_i, thr_dat_i, load_req_i, load_mask_i,
        output thresh_o, thresh_wr_o, thresh_update_o, busy_o, done_o, wr_err_o, fsm_state_o
    );

    modport master (
        output thr_we_i, thr_set_i, thr_addr_i, thr_dat_i, load_req_i, load_mask_i,
        input  thresh_o, thresh_wr_o, thresh_update_o, busy_o, done_o, wr_err_o, fsm_state_o
    );
endinterface

// File: rtl/beam_threshold_loader.sv
// Streams a two-bank threshold buffer into the beam-module cascade (farthest
// stage first), waits for it to settle, then fires one common update strobe.
module beam_threshold_loader #(
    parameter int NSTAGE     = 48,
    parameter int SETTLE_CYC = 4,
    parameter int ADDRW      = $clog2(NSTAGE)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    beam_threshold_loader_if.slave  bus
);
    localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [ADDRW:0] NSTAGE_LIM = (ADDRW + 1)'(NSTAGE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        SETTLE = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t         state, stateNext;
    logic [1:0]     loadMask;
    logic [IW-1:0]  rdPtr;
    logic [CW-1:0]  settleCnt;
    logic [35:0]    threshQ;
    logic [1:0]     threshWrQ;
    logic           wrErrQ;
    logic           busy, done;
    logic [1:0]     update;
    logic           addrOk, wrOk, loadAccept;
    logic [IW-1:0]  wrIdx;

    // Distributed RAM, intentionally not reset so a reset keeps the programmed thresholds.
    logic [17:0] bankA [NSTAGE];
    logic [17:0] bankB [NSTAGE];

    assign addrOk     = {1'b0, bus.thr_addr_i} < NSTAGE_LIM;
    assign wrOk       = bus.thr_we_i && !busy && addrOk;
    assign wrIdx      = bus.thr_addr_i[IW-1:0];
    assign loadAccept = (state == IDLE) && bus.load_req_i && (bus.load_mask_i != 2'b00);

    always_comb begin
        stateNext = state;
        busy      = 1'b1;
        done      = 1'b0;
        update    = 2'b00;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (loadAccept) stateNext = STREAM;
            end
            STREAM: if (rdPtr == '0) stateNext = SETTLE;
            SETTLE: if (settleCnt == CW'(SETTLE_CYC)) stateNext = UPDATE;
            UPDATE: begin
                done      = 1'b1;
                update    = loadMask;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            loadMask  <= 2'b00;
            rdPtr     <= '0;
            settleCnt <= '0;
            threshQ   <= '0;
            threshWrQ <= 2'b00;
            wrErrQ    <= 1'b0;
        end else begin
            state  <= stateNext;
            wrErrQ <= bus.thr_we_i && (busy || !addrOk);
            if (loadAccept) begin
                loadMask <= bus.load_mask_i;
                rdPtr    <= IW'(NSTAGE - 1);
            end else if (state == STREAM && rdPtr != '0) begin
                rdPtr <= rdPtr - 1'b1;
            end
            settleCnt <= (state == SETTLE) ? settleCnt + 1'b1 : '0;
            // Data is one cycle behind the address; it holds between strobes.
            if (state == STREAM) begin
                threshQ   <= {bankB[rdPtr], bankA[rdPtr]};
                threshWrQ <= loadMask;
            end else begin
                threshWrQ <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wrOk) begin
            if (bus.thr_set_i) bankB[wrIdx] <= bus.thr_dat_i;
            else               bankA[wrIdx] <= bus.thr_dat_i;
        end
    end

    assign bus.thresh_o        = threshQ;
    assign bus.thresh_wr_o     = threshWrQ;
    assign bus.thresh_update_o = update;
    assign bus.busy_o          = busy;
    assign bus.done_o          = done;
    assign bus.wr_err_o        = wrErrQ;
    assign bus.fsm_state_o     = state;
endmodule

// File: tb/tb_beam_threshold_loader.sv
// Bench for beam_threshold_loader: stream data checked through an expected queue,
// cycle timing checked in the driver, and a two-module cascade model at the end.
module tb_beam_threshold_loader;
  localparam int N = 4;
  localparam int S = 4;
  localparam int AW = 3;
  localparam int T = N + 2 + S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  beam_threshold_loader_if #(.ADDRW(AW)) bus ();

  beam_threshold_loader #(.NSTAGE(N), .SETTLE_CYC(S), .ADDRW(AW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [17:0] bank_m [2][N];
  logic [17:0] shadow [2][N];
  logic [17:0] active [2][N];
  logic [37:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] mask);
    if (mask != 2'b00)
      for (int k = N - 1; k >= 0; k--) exp_q.push_back({mask, bank_m[1][k], bank_m[0][k]});
  endtask

  // Cascade of two beam modules, N/2 stages each, seen as one N-deep shift chain per set.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.thresh_wr_o != 2'b00) begin
        if (exp_q.size() == 0) chk("wr_unexpected", {bus.thresh_wr_o, bus.thresh_o}, 38'd0);
        else chk("stream_data", {bus.thresh_wr_o, bus.thresh_o}, exp_q.pop_front());
        for (int s = 0; s < 2; s++)
          if (bus.thresh_wr_o[s]) begin
            for (int k = N - 1; k > 0; k--) shadow[s][k] = shadow[s][k-1];
            shadow[s][0] = bus.thresh_o[s*18 +: 18];
          end
      end
      for (int s = 0; s < 2; s++)
        if (bus.thresh_update_o[s])
          for (int k = 0; k < N; k++) active[s][k] = shadow[s][k];
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_thresh"}, bus.thresh_o, 36'd0);
    chk({tag, "_wr"}, bus.thresh_wr_o, 2'd0);
    chk({tag, "_upd"}, bus.thresh_update_o, 2'd0);
    chk({tag, "_busy"}, bus.busy_o, 1'b0);
    chk({tag, "_done"}, bus.done_o, 1'b0);
    chk({tag, "_wr_err"}, bus.wr_err_o, 1'b0);
  endtask

  task automatic buf_write(input logic set, input logic [AW-1:0] addr, input logic [17:0] dat);
    bus.thr_we_i = 1'b1;
    bus.thr_set_i = set;
    bus.thr_addr_i = addr;
    bus.thr_dat_i = dat;
    if (int'(addr) < N) bank_m[set][addr] = dat;
    @(posedge clk); #1;
    bus.thr_we_i = 1'b0;
    @(negedge clk);
    chk("wr_err_write", bus.wr_err_o, (int'(addr) >= N) ? 1'b1 : 1'b0);
    @(posedge clk); #1;
  endtask

  // Called at #1 after the edge that opens cycle 0; returns at the same point of cycle T+1.
  task automatic run_load(input logic [1:0] mask, input int err_cyc, input bit hold,
                          input bit wr0, input logic [17:0] wr0_val);
    bit act;
    act = (mask != 2'b00);
    if (wr0) bank_m[0][0] = wr0_val;
    push_exp(mask);
    bus.load_mask_i = mask;
    for (int c = 0; c <= T; c++) begin
      bus.load_req_i = (c == 0) || hold || (c == err_cyc);
      bus.thr_we_i = (c == err_cyc) || (wr0 && c == 0);
      bus.thr_set_i = 1'b0;
      bus.thr_addr_i = (c == err_cyc) ? AW'(1) : AW'(0);
      bus.thr_dat_i = (c == err_cyc) ? 18'h3BB : wr0_val;
      @(negedge clk);
      chk("busy", bus.busy_o, (act && c >= 1 && c <= T) ? 1'b1 : 1'b0);
      chk("thresh_wr", bus.thresh_wr_o, (act && c >= 2 && c <= N + 1) ? mask : 2'b00);
      chk("thresh_update", bus.thresh_update_o, (act && c == T) ? mask : 2'b00);
      chk("done", bus.done_o, (act && c == T) ? 1'b1 : 1'b0);
      chk("wr_err_load", bus.wr_err_o, (err_cyc >= 0 && c == err_cyc + 1) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    bus.load_req_i = hold;
    bus.thr_we_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", bus.busy_o, 1'b0);
      chk("idle_update", bus.thresh_update_o, 2'b00);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_cascade(input logic [1:0] mask);
    for (int s = 0; s < 2; s++)
      if (mask[s])
        for (int k = 0; k < N; k++) chk($sformatf("cascade_s%0d_k%0d", s, k), active[s][k], bank_m[s][k]);
  endtask

  task automatic reset_mid_load();
    push_exp(2'b11);
    bus.load_mask_i = 2'b11;
    bus.load_req_i = 1'b1;
    @(posedge clk); #1;
    bus.load_req_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(T + 2);
  endtask

  initial begin
    bus.thr_we_i = 1'b0;
    bus.thr_set_i = 1'b0;
    bus.thr_addr_i = '0;
    bus.thr_dat_i = '0;
    bus.load_req_i = 1'b0;
    bus.load_mask_i = 2'b00;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < N; k++) begin
        shadow[s][k] = '0;
        active[s][k] = '0;
        bank_m[s][k] = '0;
      end
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < N; k++) begin
      buf_write(1'b0, AW'(k), 18'h100 + 18'(k));
      buf_write(1'b1, AW'(k), 18'h200 + 18'(k));
    end

    run_load(2'b11, -1, 1'b0, 1'b0, 18'h0);
    check_cascade(2'b11);
    run_load(2'b10, -1, 1'b0, 1'b0, 18'h0);
    check_cascade(2'b10);
    run_load(2'b00, -1, 1'b0, 1'b0, 18'h0);

    buf_write(1'b0, AW'(5), 18'h3AA);
    run_load(2'b11, 3, 1'b0, 1'b0, 18'h0);
    idle_cycles(3);
    run_load(2'b11, -1, 1'b0, 1'b0, 18'h0);
    check_cascade(2'b11);

    run_load(2'b01, -1, 1'b0, 1'b1, 18'h155);
    check_cascade(2'b01);

    run_load(2'b11, -1, 1'b1, 1'b0, 18'h0);
    run_load(2'b11, -1, 1'b0, 1'b0, 18'h0);
    check_cascade(2'b11);

    reset_mid_load();
    run_load(2'b11, -1, 1'b0, 1'b0, 18'h0);
    check_cascade(2'b11);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
